// File: rtl/det_pkg.sv
// rtl/det_pkg.sv - op codes, FSM state encoding and defaults for the determinant sequencer
package det_pkg;

  localparam int DET_N = 8;

  localparam logic [1:0] OP_ELIM = 2'd0;
  localparam logic [1:0] OP_SWAP = 2'd1;
  localparam logic [1:0] OP_DIAG = 2'd2;

  typedef enum logic [2:0] {S_I, S_LOAD, S_PIVOT, S_SWAP, S_ELIM, S_DIAG, S_DONE} state_t;

  localparam int Q_I     = 0;
  localparam int Q_LOAD  = 1;
  localparam int Q_PIVOT = 2;
  localparam int Q_ELIM  = 3;
  localparam int Q_DIAG  = 4;
  localparam int Q_DONE  = 5;

  // A pending row swap is still part of pivoting, so it reports as q_Pivot.
  function automatic logic [5:0] state_flags(state_t s);
    logic [5:0] f;
    f = '0;
    case (s)
      S_I:             f[Q_I]     = 1'b1;
      S_LOAD:          f[Q_LOAD]  = 1'b1;
      S_PIVOT, S_SWAP: f[Q_PIVOT] = 1'b1;
      S_ELIM:          f[Q_ELIM]  = 1'b1;
      S_DIAG:          f[Q_DIAG]  = 1'b1;
      S_DONE:          f[Q_DONE]  = 1'b1;
      default:         f          = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/det_elim_iter.sv
// rtl/det_elim_iter.sv - (k,i,j) elimination counter: i ascends below pivot k, j descends from N-1 to k
module det_elim_iter import det_pkg::*; #(
  parameter int N = DET_N,
  localparam int RW = $clog2(N)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clear,
  input  logic          step,
  output logic [RW-1:0] k,
  output logic [RW-1:0] i,
  output logic [RW-1:0] j,
  output logic          last_j,
  output logic          last_i,
  output logic          last_k
);

  localparam logic [RW-1:0] LAST = RW'(N - 1);

  assign last_j = (j == k);
  assign last_i = (i == LAST);
  assign last_k = (k == RW'(N - 2));

  // i/j are always pre-positioned at (k+1, N-1) so a new pivot column starts without a bubble.
  always_ff @(posedge Clk) begin
    if (!Reset || clear) begin
      k <= '0;
      i <= RW'(1);
      j <= LAST;
    end else if (step) begin
      if (!last_j) begin
        j <= j - RW'(1);
      end else begin
        j <= LAST;
        if (!last_i) begin
          i <= i + RW'(1);
        end else begin
          k <= k + RW'(1);
          i <= k + RW'(2);
        end
      end
    end
  end

endmodule

// File: rtl/det_elim_ctrl.sv
// rtl/det_elim_ctrl.sv - determinant sequencer: matrix load, pivot search, swap, elimination and diagonal product
module det_elim_ctrl import det_pkg::*; #(
  parameter int N = DET_N,
  localparam int RW = $clog2(N)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Ack,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [RW-1:0] wr_row,
  output logic [RW-1:0] wr_col,
  output logic [RW-1:0] piv_row,
  output logic [RW-1:0] piv_col,
  input  logic          piv_nz,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [1:0]    op_code,
  output logic [RW-1:0] op_k,
  output logic [RW-1:0] op_i,
  output logic [RW-1:0] op_j,
  output logic          neg_sign,
  output logic          singular,
  output logic          q_I,
  output logic          q_Load,
  output logic          q_Pivot,
  output logic          q_Elim,
  output logic          q_Diag,
  output logic          q_Done
);

  localparam logic [RW-1:0] LAST = RW'(N - 1);

  state_t        state, nstate;
  logic [RW-1:0] r;
  logic [RW-1:0] lrow, lcol;
  logic [RW-1:0] k, i, j;
  logic          last_i, last_j, last_k;
  logic          it_clear, it_step;

  det_elim_iter #(.N(N)) u_iter (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (it_clear),
    .step   (it_step),
    .k      (k),
    .i      (i),
    .j      (j),
    .last_j (last_j),
    .last_i (last_i),
    .last_k (last_k)
  );

  assign wr_en   = in_valid && in_ready;
  assign wr_row  = lrow;
  assign wr_col  = lcol;
  assign piv_row = r;
  assign piv_col = k;
  assign {q_Done, q_Diag, q_Elim, q_Pivot, q_Load, q_I} = state_flags(state);

  // Op fields derive only from registered counters, so they hold steady while stalled.
  always_comb begin
    nstate   = state;
    in_ready = 1'b0;
    op_valid = 1'b0;
    op_code  = OP_ELIM;
    op_k     = '0;
    op_i     = '0;
    op_j     = '0;
    it_clear = 1'b0;
    it_step  = 1'b0;
    case (state)
      S_I: begin
        it_clear = 1'b1;
        if (Start) nstate = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && lrow == LAST && lcol == LAST) nstate = S_PIVOT;
      end
      S_PIVOT: begin
        if (piv_nz)          nstate = (r == k) ? S_ELIM : S_SWAP;
        else if (r == LAST)  nstate = S_DONE;
      end
      S_SWAP: begin
        op_valid = 1'b1;
        op_code  = OP_SWAP;
        op_k     = k;
        op_i     = r;
        op_j     = k;
        if (op_ready) nstate = S_ELIM;
      end
      S_ELIM: begin
        op_valid = 1'b1;
        op_code  = OP_ELIM;
        op_k     = k;
        op_i     = i;
        op_j     = j;
        if (op_ready) begin
          it_step = 1'b1;
          if (last_i && last_j) nstate = last_k ? S_DIAG : S_PIVOT;
        end
      end
      S_DIAG: begin
        op_valid = 1'b1;
        op_code  = OP_DIAG;
        op_k     = r;
        op_i     = r;
        op_j     = r;
        if (op_ready && r == LAST) nstate = S_DONE;
      end
      S_DONE: begin
        if (Ack) nstate = S_I;
      end
      default: nstate = S_I;
    endcase
  end

  // r is the probe row during pivoting and the diagonal index during DIAG.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= S_I;
      r        <= '0;
      lrow     <= '0;
      lcol     <= '0;
      neg_sign <= 1'b0;
      singular <= 1'b0;
    end else begin
      state <= nstate;
      case (state)
        S_I: if (Start) begin
          r        <= '0;
          lrow     <= '0;
          lcol     <= '0;
          neg_sign <= 1'b0;
          singular <= 1'b0;
        end
        S_LOAD: if (wr_en) begin
          if (lcol == LAST) begin
            lcol <= '0;
            lrow <= lrow + RW'(1);
          end else begin
            lcol <= lcol + RW'(1);
          end
        end
        S_PIVOT: if (!piv_nz) begin
          if (r == LAST) singular <= 1'b1;
          else           r        <= r + RW'(1);
        end
        S_SWAP: if (op_ready) neg_sign <= ~neg_sign;
        S_ELIM: if (op_ready && last_i && last_j) r <= last_k ? '0 : k + RW'(1);
        S_DIAG: if (op_ready && r != LAST) r <= r + RW'(1);
        default: ;
      endcase
    end
  end

endmodule
